booth_mult: RTL

Sequential radix-2 Booth multiplier for the processor's execute stage. It sits directly downstream of the arithmetic-right-shift barrel datapath and performs one add/subtract plus a 1-bit arithmetic right shift of the product register per cycle. It produces a signed 32-bit product, an overflow flag and a one-cycle ready pulse. Multiply instructions stall the pipeline on it until ready.

---
 rtl/booth_mult.sv | 105 ++++++++++
 1 files changed

// File: rtl/booth_mult.sv
// Sequential radix-2 Booth multiplier: one add/subtract plus a 1-bit arithmetic
// right shift per cycle, 32 iterations, registered product, overflow and ready pulse.
module booth_mult #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ctrl_MULT,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY
);

    localparam int unsigned CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t state_q, state_d;

    logic [WIDTH:0]   m_reg;
    logic [WIDTH:0]   a_reg;
    logic [WIDTH-1:0] q_reg;
    logic             q_m1;
    logic [CW-1:0]    count;

    logic [WIDTH:0]   a_sum;
    logic [WIDTH:0]   a_next;
    logic [WIDTH-1:0] q_next;
    logic             q_m1_next;
    logic             overflow;
    logic             iterate;
    logic             finish;

    // Accumulator is one bit wider than the operands so A - M cannot wrap for M = -2^(W-1).
    always_comb begin
        a_sum = a_reg;
        case ({q_reg[0], q_m1})
            2'b01:   a_sum = a_reg + m_reg;
            2'b10:   a_sum = a_reg - m_reg;
            default: a_sum = a_reg;
        endcase
        {a_next, q_next, q_m1_next} = {a_sum[WIDTH], a_sum, q_reg};
        overflow = (a_next[WIDTH-1:0] != {WIDTH{q_next[WIDTH-1]}}) ||
                   (a_next[WIDTH] != a_next[WIDTH-1]);
    end

    // A start strobe always wins, so it aborts a running operation.
    assign iterate = (state_q == S_RUN) && !ctrl_MULT;
    assign finish  = iterate && (count == LAST);

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  state_d = S_IDLE;
            S_RUN:   if (count == LAST) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (ctrl_MULT) state_d = S_RUN;
        data_resultRDY = (state_q == S_DONE);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            m_reg          <= '0;
            a_reg          <= '0;
            q_reg          <= '0;
            q_m1           <= 1'b0;
            count          <= '0;
            data_result    <= '0;
            data_exception <= 1'b0;
        end else if (ctrl_MULT) begin
            m_reg <= {data_operandA[WIDTH-1], data_operandA};
            a_reg <= '0;
            q_reg <= data_operandB;
            q_m1  <= 1'b0;
            count <= '0;
        end else if (iterate) begin
            a_reg <= a_next;
            q_reg <= q_next;
            q_m1  <= q_m1_next;
            count <= count + 1'b1;
            if (finish) begin
                data_result    <= q_next;
                data_exception <= overflow;
            end
        end
    end

endmodule
